// File: rtl/lnl_uart_rx.sv
// lnl_uart_rx: 16x-oversampled 8N1 serial receiver feeding a small valid/ready read FIFO.
// Define LNL_UART_RX_PARITY_EN to add an even-parity bit, a PARITY state and the parity_err pulse.
module lnl_uart_rx #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_pin,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        busy
`ifdef LNL_UART_RX_PARITY_EN
  ,
  output logic                        parity_err
`endif
);

  localparam int              PW        = $clog2(FIFO_DEPTH);
  localparam logic [9:0]      BAUD_LAST = 10'(BAUD_DIV - 1);
  localparam logic [PW:0]     LVL_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]     LVL_ONE   = (PW + 1)'(1);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

  // state | meaning: IDLE wait for low | START mid-start check | DATA 8 bits | PARITY | STOP | BREAK wait for high
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef LNL_UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_BREAK  = 3'd4
  } state_t;

  logic [1:0]  sync_q;
  logic        rx_s;
  logic [9:0]  baud_q;
  logic        tick;
  state_t      state_q;
  logic [3:0]  smp_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        frame_err_q;
  logic        smp_end;
  logic        par_ok;
  logic        push;

  assign rx_s    = sync_q[1];
  assign tick    = (baud_q == BAUD_LAST);
  assign smp_end = tick && (smp_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      baud_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_pin};
      baud_q <= tick ? '0 : baud_q + 10'd1;
    end
  end

`ifdef LNL_UART_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  assign par_ok     = !par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      smp_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef LNL_UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef LNL_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            smp_q   <= '0;
`ifdef LNL_UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            if (smp_q == 4'd7) begin
              smp_q   <= '0;
              bit_q   <= '0;
              state_q <= rx_s ? S_IDLE : S_DATA;
            end else begin
              smp_q <= smp_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            smp_q <= smp_q + 4'd1;
            if (smp_q == 4'd15) begin
              shift_q <= {rx_s, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
`ifdef LNL_UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end
          end
        end
`ifdef LNL_UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            smp_q <= smp_q + 4'd1;
            if (smp_q == 4'd15) begin
              par_bad_q    <= ^{shift_q, rx_s};
              parity_err_q <= ^{shift_q, rx_s};
              state_q      <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            smp_q <= smp_q + 4'd1;
            if (smp_q == 4'd15) begin
              if (rx_s) begin
                state_q <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign push = (state_q == S_STOP) && smp_end && rx_s && par_ok;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [PW:0]   level_q;
  logic [PW:0]   level_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    rd_data_d;
  logic          rd_valid_q;
  logic          overrun_q;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovr_d;

  assign full  = (level_q == LVL_FULL);
  assign pop   = rd_valid_q && rd_ready;
  assign wr_en = push && (!full || pop);
  assign ovr_d = push && full && !pop;

  // rd_data is a register holding the next head, including a byte landing in an empty FIFO.
  always_comb begin
    rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d   = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!wr_en && pop) begin
      level_d = level_q - LVL_ONE;
    end
    rd_data_d = rd_data_q;
    if (level_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
        rd_data_d = shift_q;
      end else begin
        rd_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= (level_d != '0);
      overrun_q  <= ovr_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
